// File: rtl/aes128_encrypt_iter_if.sv
// Request/result bundle for the iterative AES-128 encryptor.
// The master side supplies the key and block and receives the ciphertext
// together with the round-10 key.
interface aes128_encrypt_iter_if;
    logic         start;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;
    logic [127:0] key_last;

    modport master (
        output start, key, plaintext,
        input  busy, done, ciphertext, key_last
    );

    modport slave (
        input  start, key, plaintext,
        output busy, done, ciphertext, key_last
    );
endinterface

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor with one cipher round per clock.
// The round key is expanded on the fly alongside the data. The round-10 key
// is exported so that a decryptor can start its inverse key schedule from it.
// Byte n of any 128-bit word sits at bits [127-8n -: 8], in column-major order.
module aes128_encrypt_iter (
    input  logic                  clk,
    input  logic                  rst,
    aes128_encrypt_iter_if.slave  bus
);

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] kl_q, kl_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product. It is used only for the inverse inside the S-box.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Forward S-box: the inverse is computed as x^254, followed by the affine transform.
    // Zero maps through the inverse to zero, which the AES definition requires.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Mix one column: the fixed circulant matrix {02 03 01 01}.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [127:0] sb_out;
    logic [127:0] sr_out;
    logic [127:0] mc_out;
    logic [127:0] round_out;
    logic [127:0] next_key;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  w4, w5, w6, w7;

    genvar gi;

    // sub_bytes: apply the S-box to each of the 16 state bytes.
    for (gi = 0; gi < 16; gi++) begin : g_sub_bytes
        assign sb_out[127-8*gi -: 8] = sbox(state_q[127-8*gi -: 8]);
    end

    // shift_rows: row r rotates left by r columns, so out[r][c] = in[r][(c+r)%4].
    for (gi = 0; gi < 16; gi++) begin : g_shift_rows
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
        assign sr_out[127-8*gi -: 8] = sb_out[127-8*SRC -: 8];
    end

    // mix_columns: mix each of the four columns independently.
    for (gi = 0; gi < 4; gi++) begin : g_mix_columns
        assign mc_out[127-32*gi -: 32] = mix_column(sr_out[127-32*gi -: 32]);
    end

    // Key expansion step: SubWord(RotWord(w3)) uses the same S-box as the data path.
    assign rot_w3 = {rkey_q[23:0], rkey_q[31:24]};
    for (gi = 0; gi < 4; gi++) begin : g_sub_word
        assign sub_w3[31-8*gi -: 8] = sbox(rot_w3[31-8*gi -: 8]);
    end

    assign w4       = rkey_q[127:96] ^ sub_w3 ^ {rcon_q, 24'h000000};
    assign w5       = rkey_q[95:64] ^ w4;
    assign w6       = rkey_q[63:32] ^ w5;
    assign w7       = rkey_q[31:0] ^ w6;
    assign next_key = {w4, w5, w6, w7};

    // add_round_key. The final round skips MixColumns.
    assign round_out = ((rnd_q == 4'd10) ? sr_out : mc_out) ^ next_key;

    // Next-state logic: load the block on start, then run ten rounds and report the result.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        rcon_d  = rcon_q;
        rnd_d   = rnd_q;
        ct_d    = ct_q;
        kl_d    = kl_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = bus.plaintext ^ bus.key;
                    rkey_d  = bus.key;
                    rcon_d  = 8'h01;
                    rnd_d   = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (rnd_q == 4'd0 || rnd_q > 4'd10) begin
                    // A corrupted round counter abandons the block without a done pulse.
                    fsm_d = IDLE;
                    rnd_d = 4'd0;
                end else begin
                    state_d = round_out;
                    rkey_d  = next_key;
                    rcon_d  = xtime(rcon_q);
                    rnd_d   = rnd_q + 4'd1;
                    if (rnd_q == 4'd10) begin
                        ct_d   = round_out;
                        kl_d   = next_key;
                        done_d = 1'b1;
                        fsm_d  = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers. A synchronous reset clears everything, including the held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            rcon_q  <= '0;
            rnd_q   <= '0;
            ct_q    <= '0;
            kl_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            rcon_q  <= rcon_d;
            rnd_q   <= rnd_d;
            ct_q    <= ct_d;
            kl_q    <= kl_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy       = (fsm_q == RUN);
    assign bus.done       = done_q;
    assign bus.ciphertext = ct_q;
    assign bus.key_last   = kl_q;

endmodule
